// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its skid FIFO.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HALT,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small skid FIFO of fetched {pc, instruction} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t pop_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter sequencer: fetches words into a skid FIFO, handles redirects,
// halts on the zero padding word and traps on illegal fetch addresses.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_WORDS  = 1280,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, flush, pop, fifo_full, fifo_empty;
  logic         pc_illegal, redirect_illegal;
  fetch_entry_t push_entry, head_entry;

  assign pc_illegal       = (pc_q >= PC_LIMIT);
  assign redirect_illegal = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);
  assign pop              = out_valid && out_ready;
  assign push_entry       = '{pc: pc_q, instruction: imem_instruction};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      FETCH, HALT: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_illegal) begin
            state_d = FAULT;
          end else begin
            pc_d    = redirect_pc;
            state_d = FETCH;
          end
        end else if (state_q == FETCH) begin
          // The PC stepped past the last word: trap before using the bogus read.
          if (pc_illegal) begin
            state_d = FAULT;
            flush   = 1'b1;
          end else if (!fifo_full || pop) begin
            if (imem_instruction == HALT_WORD) begin
              state_d = HALT;
            end else begin
              push = 1'b1;
              pc_d = pc_q + PC_STEP;
            end
          end
        end
      end
      FAULT: ;
      default: state_d = FAULT;
    endcase
  end

  always_comb begin
    imem_address    = pc_q;
    out_valid       = !fifo_empty && (state_q != FAULT);
    out_instruction = head_entry.instruction;
    out_pc          = head_entry.pc;
    halted          = (state_q == HALT) && fifo_empty;
    fault           = (state_q == FAULT);
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a 1280-word memory instance and a
// 4-word instance for the run-off-the-end trap.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, out_ready;
  logic [31:0] imem_address, imem_instruction, redirect_pc, out_instruction, out_pc;
  logic        out_valid, halted, fault;

  logic        reset2, out_ready2;
  logic [31:0] imem_address2, imem_instruction2, out_instruction2, out_pc2;
  logic        out_valid2, halted2, fault2;

  logic [31:0] mem [1280];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0),
    .MEM_WORDS (1280),
    .FIFO_DEPTH(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .halted          (halted),
    .fault           (fault)
  );

  instruction_fetch_unit #(
    .RESET_PC  (32'h0),
    .MEM_WORDS (4),
    .FIFO_DEPTH(2)
  ) dut_small (
    .clk             (clk),
    .reset           (reset2),
    .imem_address    (imem_address2),
    .imem_instruction(imem_instruction2),
    .redirect_valid  (1'b0),
    .redirect_pc     (32'h0),
    .out_valid       (out_valid2),
    .out_ready       (out_ready2),
    .out_instruction (out_instruction2),
    .out_pc          (out_pc2),
    .halted          (halted2),
    .fault           (fault2)
  );

  always_comb begin
    imem_instruction = 32'h0;
    if (imem_address < 32'd5120) imem_instruction = mem[imem_address[12:2]];
  end

  // Every word of the small memory (and beyond) is nonzero, so it never halts.
  assign imem_instruction2 = imem_address2 | 32'h13;

  function automatic logic [31:0] prog_word(int i);
    return 32'h0000_2083 + 32'(i) * 32'h100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1280; i++) mem[i] = (i < 12) ? prog_word(i) : 32'h0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    reset2 = 1'b1; out_ready2 = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_instr", out_instruction, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_addr", imem_address, 32'h0);
    reset = 1'b0;

    // Back-to-back stream of 12 instructions, then halt on word 12.
    tick();
    chk("first_instr", out_instruction, 32'h0000_2083);
    for (int i = 0; i < 12; i++) begin
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc", out_pc, 32'(4 * i));
      chk("stream_instr", out_instruction, prog_word(i));
      tick();
    end
    chk("halt_valid", 32'(out_valid), 32'd0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addr", imem_address, 32'd48);
    tick();
    tick();
    chk("halt_hold_addr", imem_address, 32'd48);
    chk("halt_hold_flag", 32'(halted), 32'd1);

    // Redirect out of HALT resumes fetching at 0.
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("resume_valid", 32'(out_valid), 32'd0);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_addr", imem_address, 32'd0);
    tick();
    chk("resume_valid2", 32'(out_valid), 32'd1);
    chk("resume_pc", out_pc, 32'd0);

    // Back-pressure: FIFO fills with 0 and 4, PC parks at 8.
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", out_pc, 32'd0);
    chk("bp_addr", imem_address, 32'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_pc", out_pc, 32'(4 * i));
      tick();
    end

    // Redirect to 36 with pc 16 at the head.
    chk("redir_head", out_pc, 32'd16);
    redirect_valid = 1'b1; redirect_pc = 32'd36;
    tick();
    redirect_valid = 1'b0;
    chk("redir_gap", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("redir_valid", 32'(out_valid), 32'd1);
      chk("redir_pc", out_pc, 32'(36 + 4 * i));
    end
    tick();
    chk("redir_halt", 32'(halted), 32'd1);

    // Misaligned redirect traps; later redirects are ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(out_valid), 32'd0);
    chk("mis_addr", imem_address, 32'd48);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("mis_sticky", 32'(fault), 32'd1);
    chk("mis_ignored_addr", imem_address, 32'd48);
    chk("mis_ignored_valid", 32'(out_valid), 32'd0);

    // Reset from FAULT, fill FIFO with 40/44 so the halt word at 48 is pending, then reset.
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'd40;
    tick();
    redirect_valid = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    tick();
    tick();
    tick();
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_head", out_pc, 32'd40);
    chk("full_addr", imem_address, 32'd48);
    chk("full_halted", 32'(halted), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_addr", imem_address, 32'd0);
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_halted", 32'(halted), 32'd0);

    // Out-of-range redirect target.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'd5120;
    tick();
    redirect_valid = 1'b0;
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_valid", 32'(out_valid), 32'd0);

    // Small memory: deliver 0..12, then trap when the PC steps past word 3.
    reset2 = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("small_valid", 32'(out_valid2), 32'd1);
      chk("small_pc", out_pc2, 32'(4 * i));
      chk("small_instr", out_instruction2, 32'(4 * i) | 32'h13);
      chk("small_nofault", 32'(fault2), 32'd0);
      tick();
    end
    chk("small_fault", 32'(fault2), 32'd1);
    chk("small_fault_valid", 32'(out_valid2), 32'd0);
    chk("small_halted", 32'(halted2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
